// File: rtl/vl_spec_adder.sv
// vl_spec_adder: variable-latency wrapper around a windowed-carry speculative
// adder. The speculative sum is used when the detector sees no long propagate
// run fed by a real carry; otherwise one extra cycle produces the exact sum.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// CALC  | speculative sum and error detect on captured operands
// CORR  | speculation failed, load exact sum
// OUT   | result presented, held until out_ready
module vl_spec_adder #(
  parameter int WIDTH = 8,
  parameter int WIN   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Spec_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_CORR, S_OUT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_err;
  logic [CNT_W-1:0] r_op_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH:0]   w_c_exact;
  logic [WIDTH:0]   w_c_spec;
  logic [WIDTH-1:0] w_sum_spec;
  logic [WIDTH-1:0] w_sum_exact;
  logic             w_err;
  logic             w_accept;
  logic             w_load_spec;
  logic             w_load_exact;
  logic             w_hs;

  // Carry generation: exact ripple, windowed speculative carries and the
  // detector that flags a full propagate window fed by a real carry.
  always_comb begin
    logic [WIDTH:0] v_cx;
    logic           v_c;
    w_p     = r_a ^ r_b;
    w_g     = r_a & r_b;
    v_cx    = '0;
    v_cx[0] = r_cin;
    for (int i = 0; i < WIDTH; i++) begin
      v_cx[i+1] = w_g[i] | (w_p[i] & v_cx[i]);
    end
    w_c_exact   = v_cx;
    w_c_spec    = '0;
    w_c_spec[0] = r_cin;
    for (int i = 1; i <= WIDTH; i++) begin
      // Low carries see the whole prefix; higher ones only WIN bits, cin=0.
      v_c = (i <= WIN) ? r_cin : 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
        if (j < i && (i <= WIN || j >= i - WIN)) begin
          v_c = w_g[j] | (w_p[j] & v_c);
        end
      end
      w_c_spec[i] = v_c;
    end
    w_sum_spec  = w_p ^ w_c_spec[WIDTH-1:0];
    w_sum_exact = w_p ^ w_c_exact[WIDTH-1:0];
    w_err       = 1'b0;
    for (int k = 1; k <= WIDTH - WIN; k++) begin
      if ((&w_p[k +: WIN]) && w_c_exact[k]) begin
        w_err = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, handshake and load-enable decode.
  always_comb begin
    w_state_nxt  = r_state;
    in_ready     = 1'b0;
    w_accept     = 1'b0;
    w_load_spec  = 1'b0;
    w_load_exact = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (w_err) begin
          w_state_nxt = S_CORR;
        end else begin
          w_load_spec = 1'b1;
          w_state_nxt = S_OUT;
        end
      end
      S_CORR: begin
        w_load_exact = 1'b1;
        w_state_nxt  = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = S_CALC;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture at accept; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
    end else if (w_accept) begin
      r_a   <= A;
      r_b   <= B;
      r_cin <= Cin;
    end
  end

  // Result registers, loaded from CALC (speculative) or CORR (exact).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_load_spec) begin
      r_sum  <= w_sum_spec;
      r_cout <= w_c_spec[WIDTH];
      r_err  <= 1'b0;
    end else if (w_load_exact) begin
      r_sum  <= w_sum_exact;
      r_cout <= w_c_exact[WIDTH];
      r_err  <= 1'b1;
    end
  end

  assign w_hs = out_valid & out_ready;

  // Saturating statistics; clear wins over a same-edge increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (clr_cnt) begin
      r_op_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (w_hs) begin
      if (r_op_cnt != '1) r_op_cnt <= r_op_cnt + 1'b1;
      if (r_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign out_valid = (r_state == S_OUT);
  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign Spec_err  = r_err;
  assign op_cnt    = r_op_cnt;
  assign err_cnt   = r_err_cnt;

endmodule
